// File: rtl/pipeline_flow_ctrl.sv
// Per-cycle flow sequencer for the pipelined RV32I core: PC / IF-ID / ID-EX
// write and flush control, halt drain/park FSM and saturating perf counters.
module pipeline_flow_ctrl #(
  parameter int WIDTH        = 9,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid_i,
  input  logic             pc_sel_i,
  input  logic [31:0]      branch_pc_i,
  input  logic             halt_i,
  input  logic             idex_mem_read_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  output logic             pc_write,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_target,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam int DCW = (DRAIN_CYCLES > 4) ? $clog2(DRAIN_CYCLES) : 2;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DCW-1:0]   r_drain_cnt;
  logic [DCW-1:0]   w_drain_nxt;
  logic             r_halted;
  logic             r_misalign;
  logic [CNT_W-1:0] r_redirect_count;
  logic [CNT_W-1:0] r_stall_count;

  logic w_halt_req;
  logic w_redirect_req;
  logic w_load_use;
  logic w_take_redirect;
  logic w_take_stall;
  logic w_unused_bp_hi;

  // Upper target bits are architecturally meaningless for the narrow PC.
  assign w_unused_bp_hi = &{1'b0, branch_pc_i[31:WIDTH]};

  assign w_halt_req     = ex_valid_i & halt_i;
  assign w_redirect_req = ex_valid_i & pc_sel_i & ~halt_i;
  assign w_load_use     = idex_mem_read_i & (idex_rd_i != 5'd0) &
                          ((idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i));

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_nxt     = r_drain_cnt;
    w_take_redirect = 1'b0;
    w_take_stall    = 1'b0;
    pc_write        = 1'b0;
    pc_load         = 1'b0;
    pc_target       = '0;
    ifid_write      = 1'b0;
    ifid_flush      = 1'b1;
    idex_flush      = 1'b1;

    if (reset) begin
      w_state_nxt = ST_RUN;
      w_drain_nxt = '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_halt_req) begin
            // Halt target (0xFFFFFFFF) is deliberately never loaded.
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = DRAIN_LOAD;
          end else if (w_redirect_req) begin
            w_take_redirect = 1'b1;
            pc_write        = 1'b1;
            pc_load         = 1'b1;
            pc_target       = branch_pc_i[WIDTH-1:0];
            ifid_write      = 1'b1;
          end else if (w_load_use) begin
            w_take_stall = 1'b1;
            ifid_flush   = 1'b0;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_drain_nxt = r_drain_cnt - DCW'(1);
          end
        end
        ST_HALTED: begin
          w_state_nxt = ST_HALTED;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_RUN;
      r_drain_cnt      <= '0;
      r_halted         <= 1'b0;
      r_misalign       <= 1'b0;
      r_redirect_count <= '0;
      r_stall_count    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_state_nxt == ST_HALTED) begin
        r_halted <= 1'b1;
      end
      if (w_take_redirect) begin
        if (branch_pc_i[1:0] != 2'b00) begin
          r_misalign <= 1'b1;
        end
        if (r_redirect_count != '1) begin
          r_redirect_count <= r_redirect_count + CNT_W'(1);
        end
      end
      if (w_take_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign halted         = r_halted;
  assign misalign_err   = r_misalign;
  assign redirect_count = r_redirect_count;
  assign stall_count    = r_stall_count;

endmodule
